// File: rtl/clock_divider_multi.sv
// clock_divider_multi: N_CH runtime-programmable square-wave dividers with rising-edge ticks.
// Latency: all outputs registered; a load/sync/enable change is visible one board_clk edge later.
// Backpressure: none; strobes are consumed on the edge they are sampled, bad loads pulse load_err.
module clock_divider_multi #(
  parameter int SYS_CLK_HZ   = 1000,
  parameter int OUT_CLK_HZ   = 4,
  parameter int N_CH         = 2,
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = SYS_CLK_HZ / (2 * OUT_CLK_HZ),
  parameter int SEL_W        = 3
) (
  input  logic             board_clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  enable,
  input  logic             sync,
  input  logic             load,
  input  logic [SEL_W-1:0] load_ch,
  input  logic [CNT_W-1:0] load_half,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic             load_err
);

  // Reset half-period and channel count, sized to the registers they are compared with.
  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);
  localparam logic [SEL_W:0]   N_CH_L   = (SEL_W + 1)'(N_CH);

  logic [CNT_W-1:0] half_q [N_CH];
  logic [CNT_W-1:0] half_d [N_CH];
  logic [CNT_W-1:0] cnt_q  [N_CH];
  logic [CNT_W-1:0] cnt_d  [N_CH];
  logic [N_CH-1:0]  clk_q, clk_d;
  logic [N_CH-1:0]  tick_q, tick_d;
  logic             err_q, err_d;
  logic             load_ok;

  // Next-state: load decode, then per-channel count/toggle with sync taking priority over enable.
  always_comb begin
    load_ok = load && ({1'b0, load_ch} < N_CH_L) && (load_half != '0);
    err_d   = load && !load_ok;
    for (int i = 0; i < N_CH; i++) begin
      half_d[i] = half_q[i];
      cnt_d[i]  = cnt_q[i];
      clk_d[i]  = clk_q[i];
      tick_d[i] = 1'b0;
      // The new half-period only governs comparisons from the next edge on.
      if (load_ok && (load_ch == SEL_W'(i))) begin
        half_d[i] = load_half;
      end
      if (sync) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
      end else if (enable[i]) begin
        // half is never 0, so half-1 cannot wrap; ">=" also catches a count
        // left above a freshly shortened half and wraps it immediately.
        if (cnt_q[i] < (half_q[i] - CNT_W'(1))) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end else begin
          cnt_d[i]  = '0;
          clk_d[i]  = ~clk_q[i];
          tick_d[i] = ~clk_q[i];
        end
      end
    end
  end

  // State registers with synchronous reset that overrides sync and load.
  always_ff @(posedge board_clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        half_q[i] <= HALF_RST;
        cnt_q[i]  <= '0;
      end
      clk_q  <= '0;
      tick_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        half_q[i] <= half_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      clk_q  <= clk_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

  assign clk_out  = clk_q;
  assign tick     = tick_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: directed scenarios plus randomized traffic against an elapsed-time model.
// Latency: model advances on each rising edge; outputs compared on every falling edge.
// Backpressure: not applicable; every check is bounded by a cycle budget.
module tb_clock_divider_multi;
  localparam int N_CH  = 2;
  localparam int CNT_W = 16;
  localparam int SEL_W = 3;
  localparam int DEF_HALF = 125;

  logic             board_clk = 1'b0;
  logic             reset;
  logic [N_CH-1:0]  enable;
  logic             sync;
  logic             load;
  logic [SEL_W-1:0] load_ch;
  logic [CNT_W-1:0] load_half;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  logic             load_err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  clock_divider_multi #(
    .SYS_CLK_HZ(1000), .OUT_CLK_HZ(4), .N_CH(N_CH), .CNT_W(CNT_W),
    .DEFAULT_HALF(DEF_HALF), .SEL_W(SEL_W)
  ) dut (
    .board_clk(board_clk), .reset(reset), .enable(enable), .sync(sync),
    .load(load), .load_ch(load_ch), .load_half(load_half),
    .clk_out(clk_out), .tick(tick), .load_err(load_err)
  );

  always #5 board_clk = ~board_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each channel counts edges elapsed since its last toggle
  // and flips its level once that count reaches the half-period in force.
  int m_half [N_CH];
  int m_el   [N_CH];
  bit m_lvl  [N_CH];
  bit m_tk   [N_CH];
  bit m_err;

  always @(posedge board_clk) begin
    bit legal;
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        m_half[i] = DEF_HALF; m_el[i] = 0; m_lvl[i] = 0; m_tk[i] = 0;
      end
      m_err = 0;
    end else begin
      legal = load && (int'(load_ch) < N_CH) && (load_half != 0);
      m_err = load && !legal;
      for (int i = 0; i < N_CH; i++) begin
        m_tk[i] = 0;
        if (sync) begin
          m_el[i] = 0; m_lvl[i] = 0;
        end else if (enable[i]) begin
          if (m_el[i] + 1 >= m_half[i]) begin
            m_el[i] = 0; m_lvl[i] = !m_lvl[i]; m_tk[i] = m_lvl[i];
          end else begin
            m_el[i] = m_el[i] + 1;
          end
        end
        if (legal && int'(load_ch) == i) m_half[i] = int'(load_half);
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge board_clk) begin
    logic [N_CH-1:0] e_clk, e_tk;
    if (chk_en) begin
      for (int i = 0; i < N_CH; i++) begin
        e_clk[i] = m_lvl[i]; e_tk[i] = m_tk[i];
      end
      chk("model_clk_out", 32'(clk_out), 32'(e_clk));
      chk("model_tick", 32'(tick), 32'(e_tk));
      chk("model_load_err", 32'(load_err), 32'(m_err));
    end
  end

  task automatic pulse_load(input int ch, input int h);
    load = 1'b1; load_ch = SEL_W'(ch); load_half = CNT_W'(h);
    @(negedge board_clk);
    load = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = '0; sync = 1'b0; load = 1'b0; load_ch = '0; load_half = '0;
    repeat (3) @(negedge board_clk);
    chk_en = 1'b1;
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_load_err", 32'(load_err), 0);

    // Defaults: rises at edge 125 and 375, fall at 250.
    reset = 1'b0; enable = 2'b11;
    n = 0;
    do begin @(negedge board_clk); n++; end while (!clk_out[0] && n < 1000);
    chk("first_rise_edge", n, 125);
    chk("first_rise_both", 32'(clk_out), 3);
    chk("first_rise_tick", 32'(tick), 3);
    @(negedge board_clk); n++;
    chk("tick_one_cycle", 32'(tick), 0);
    do begin @(negedge board_clk); n++; end while (clk_out[0] && n < 1000);
    chk("first_fall_edge", n, 250);
    do begin @(negedge board_clk); n++; end while (!tick[0] && n < 1000);
    chk("second_rise_edge", n, 375);

    // Shorten ch0 to 3 while its count sits at 50.
    repeat (50) @(negedge board_clk);
    pulse_load(0, 3);
    chk("load_edge_holds", 32'(clk_out[0]), 1);
    @(negedge board_clk);
    chk("load_wraps_next", 32'(clk_out[0]), 0);
    n = 0;
    do begin @(negedge board_clk); n++; end while (!tick[0] && n < 100);
    chk("short_first_rise", n, 3);
    n = 0;
    do begin @(negedge board_clk); n++; end while (!tick[0] && n < 100);
    chk("short_period", n, 6);

    // Freeze ch1 for 40 cycles, then resume.
    enable = 2'b01;
    repeat (40) @(negedge board_clk);
    enable = 2'b11;
    repeat (150) @(negedge board_clk);

    // Rejected loads.
    pulse_load(0, 0);
    chk("err_half_zero", 32'(load_err), 1);
    @(negedge board_clk);
    chk("err_half_zero_clear", 32'(load_err), 0);
    pulse_load(5, 7);
    chk("err_bad_ch", 32'(load_err), 1);
    @(negedge board_clk);
    chk("err_bad_ch_clear", 32'(load_err), 0);

    // Sync while both high, combined with ch1 reload to 10.
    n = 0;
    while (clk_out != 2'b11 && n < 1000) begin @(negedge board_clk); n++; end
    chk("wait_both_high", 32'(clk_out), 3);
    sync = 1'b1;
    pulse_load(1, 10);
    sync = 1'b0;
    chk("sync_clears_clk", 32'(clk_out), 0);
    chk("sync_clears_tick", 32'(tick), 0);
    n = 0;
    do begin @(negedge board_clk); n++; end while (!clk_out[1] && n < 200);
    chk("sync_ch1_rise", n, 10);

    // Reset mid-period alongside sync and loads: reset dominates.
    repeat (7) @(negedge board_clk);
    reset = 1'b1; sync = 1'b1;
    pulse_load(0, 0);
    pulse_load(1, 9);
    reset = 1'b0; sync = 1'b0;
    chk("rst_mid_clk_out", 32'(clk_out), 0);
    chk("rst_mid_load_err", 32'(load_err), 0);
    n = 0;
    do begin @(negedge board_clk); n++; end while (clk_out == 0 && n < 1000);
    chk("rst_mid_rise_edge", n, 125);
    chk("rst_mid_rise_both", 32'(clk_out), 3);

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      enable[0] = ($urandom_range(0, 9) != 0);
      enable[1] = ($urandom_range(0, 9) != 0);
      sync  = ($urandom_range(0, 63) == 0);
      reset = ($urandom_range(0, 999) == 0);
      load  = ($urandom_range(0, 7) == 0);
      load_ch   = ($urandom_range(0, 3) != 0) ? SEL_W'($urandom_range(0, 1))
                                              : SEL_W'($urandom_range(0, 7));
      load_half = ($urandom_range(0, 9) == 0) ? '0 : CNT_W'($urandom_range(1, 12));
      @(negedge board_clk);
    end
    reset = 1'b0; sync = 1'b0; load = 1'b0;
    @(negedge board_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
